// File: rtl/vga_sync_decoder_if.sv
// VGA receive-side bundle: timing/RGB from the generator (master) into the
// decoder (slave), plus the decoded pixel stream and status back out.
// With VGA_DEC_STATS_EN defined the bundle also carries frame_cnt/err_cnt.
interface vga_sync_decoder_if;
  logic        pix_ce;
  logic        hsync;
  logic        vsync;
  logic [3:0]  red;
  logic [3:0]  green;
  logic [3:0]  blue;
  logic        locked;
  logic        pix_valid;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic [11:0] pix_rgb;
  logic        frame_start;
  logic        sync_err;
`ifdef VGA_DEC_STATS_EN
  logic [15:0] frame_cnt;
  logic [7:0]  err_cnt;

  modport master (
    output pix_ce, hsync, vsync, red, green, blue,
    input  locked, pix_valid, pix_x, pix_y, pix_rgb, frame_start, sync_err,
    input  frame_cnt, err_cnt
  );

  modport slave (
    input  pix_ce, hsync, vsync, red, green, blue,
    output locked, pix_valid, pix_x, pix_y, pix_rgb, frame_start, sync_err,
    output frame_cnt, err_cnt
  );
`else
  modport master (
    output pix_ce, hsync, vsync, red, green, blue,
    input  locked, pix_valid, pix_x, pix_y, pix_rgb, frame_start, sync_err
  );

  modport slave (
    input  pix_ce, hsync, vsync, red, green, blue,
    output locked, pix_valid, pix_x, pix_y, pix_rgb, frame_start, sync_err
  );
`endif
endinterface

// File: rtl/vga_sync_decoder.sv
// VGA sync decoder: re-times hsync/vsync/RGB, recovers the generator's
// horizontal/vertical counters from the sync falling edges, checks line and
// frame timing, declares lock after LOCK_FRAMES clean frames and then emits
// the active-area pixels with their coordinates.
// Optional macro VGA_DEC_STATS_EN adds frame_cnt (wrapping) and err_cnt
// (saturating) statistics outputs.
module vga_sync_decoder #(
  parameter int HPIXELS      = 800,
  parameter int VLINES       = 525,
  parameter int H_SYNC_START = 17,
  parameter int V_SYNC_START = 11,
  parameter int HBP          = 160,
  parameter int VBP          = 45,
  parameter int LOCK_FRAMES  = 2
) (
  input  logic               clk,
  input  logic               clr,
  vga_sync_decoder_if.slave  vif
);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam logic [9:0] H_LAST = 10'(HPIXELS - 1);
  localparam logic [9:0] V_LAST = 10'(VLINES - 1);
  localparam logic [9:0] H_SS   = 10'(H_SYNC_START);
  localparam logic [9:0] V_SS   = 10'(V_SYNC_START);
  localparam logic [9:0] HBP_V  = 10'(HBP);
  localparam logic [9:0] VBP_V  = 10'(VBP);
  // Line timeout: two nominal lines without an hsync fall.
  localparam int TO_LIMIT = 2 * HPIXELS;
  localparam int TO_W     = $clog2(TO_LIMIT);
  localparam int GOOD_W   = $clog2(LOCK_FRAMES + 1);
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TO_LIMIT - 1);
  localparam logic [GOOD_W-1:0] GOOD_TGT = GOOD_W'(LOCK_FRAMES);

  // Counter advance with wrap at the last position.
  function automatic logic [9:0] wrap_inc(input logic [9:0] val, input logic [9:0] last);
    return (val == last) ? 10'd0 : val + 10'd1;
  endfunction

  // ---- stage 1/2: input re-timing ----
  logic        vld_p1, vld_p2;
  logic        hs_p1, hs_p2;
  logic        vs_p1, vs_p2;
  logic [11:0] rgb_p1, rgb_p2;

  // Control side of the re-timing pipe: enable cleared, syncs idle high.
  always_ff @(posedge clk) begin
    if (clr) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      hs_p1  <= 1'b1;
      hs_p2  <= 1'b1;
      vs_p1  <= 1'b1;
      vs_p2  <= 1'b1;
    end else begin
      vld_p1 <= vif.pix_ce;
      vld_p2 <= vld_p1;
      hs_p1  <= vif.hsync;
      hs_p2  <= hs_p1;
      vs_p1  <= vif.vsync;
      vs_p2  <= vs_p1;
    end
  end

  // Pixel data rides alongside the syncs; it needs no reset.
  always_ff @(posedge clk) begin
    rgb_p1 <= {vif.red, vif.green, vif.blue};
    rgb_p2 <= rgb_p1;
  end

  // ---- stage 3: decode state and registered outputs ----
  state_t            state_q, state_d;
  logic [9:0]        h_q, h_d;
  logic [9:0]        v_q, v_d;
  logic [GOOD_W-1:0] good_q, good_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic              seen_q, seen_d;
  logic              hs_prev_q, hs_prev_d;
  logic              vs_prev_q, vs_prev_d;
  logic              locked_q, locked_d;
  logic              pix_valid_q, pix_valid_d;
  logic [9:0]        pix_x_q, pix_x_d;
  logic [9:0]        pix_y_q, pix_y_d;
  logic [11:0]       pix_rgb_q, pix_rgb_d;
  logic              frame_start_q, frame_start_d;
  logic              sync_err_q, sync_err_d;

  logic       hs_fall, vs_fall;
  logic [9:0] h_free, v_free;
  logic       h_bad, v_bad, to_hit, viol;

  // Free-running position for this tick and the timing checks against it.
  assign hs_fall = hs_prev_q & ~hs_p2;
  assign vs_fall = vs_prev_q & ~vs_p2;
  assign h_free  = wrap_inc(h_q, H_LAST);
  assign v_free  = (h_free == 10'd0) ? wrap_inc(v_q, V_LAST) : v_q;
  assign h_bad   = hs_fall && (h_free != H_SS);
  assign v_bad   = vs_fall && ((h_free != 10'd0) || (v_free != V_SS));
  assign to_hit  = !hs_fall && (to_q == TO_LAST);
  assign viol    = (state_q != SEARCH) && (h_bad || v_bad || to_hit);

  // Next-state / output decode, evaluated only on re-timed pixel ticks.
  always_comb begin
    state_d       = state_q;
    h_d           = h_q;
    v_d           = v_q;
    good_d        = good_q;
    to_d          = to_q;
    seen_d        = seen_q;
    hs_prev_d     = hs_prev_q;
    vs_prev_d     = vs_prev_q;
    pix_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    sync_err_d    = 1'b0;
    pix_x_d       = pix_x_q;
    pix_y_d       = pix_y_q;
    pix_rgb_d     = pix_rgb_q;

    if (vld_p2) begin
      hs_prev_d = hs_p2;
      vs_prev_d = vs_p2;
      // A sync fall always re-anchors its counter; in tracking states that
      // only changes anything when the fall was already flagged as bad.
      h_d = hs_fall ? H_SS : h_free;
      v_d = vs_fall ? V_SS : (hs_fall ? v_q : v_free);

      case (state_q)
        SEARCH: begin
          to_d = '0;
          if (hs_fall) seen_d = 1'b1;
          if (vs_fall && (seen_q || hs_fall)) begin
            state_d = ACQUIRE;
            good_d  = '0;
          end
        end
        default: begin
          to_d = hs_fall ? '0 : to_q + 1'b1;
          if (viol) begin
            state_d    = SEARCH;
            good_d     = '0;
            seen_d     = hs_fall;
            sync_err_d = 1'b1;
          end else if (state_q == ACQUIRE) begin
            if (vs_fall) begin
              good_d = good_q + 1'b1;
              if (good_q + 1'b1 == GOOD_TGT) state_d = LOCKED;
            end
          end else begin
            if (h_d >= HBP_V && v_d >= VBP_V) begin
              pix_valid_d = 1'b1;
              pix_x_d     = h_d - HBP_V;
              pix_y_d     = v_d - VBP_V;
              pix_rgb_d   = rgb_p2;
            end
            if (h_d == 10'd0 && v_d == 10'd0) frame_start_d = 1'b1;
          end
        end
      endcase
    end

    locked_d = (state_d == LOCKED);
  end

  // Decode register bank; clr returns everything to the idle search state.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q       <= SEARCH;
      h_q           <= '0;
      v_q           <= '0;
      good_q        <= '0;
      to_q          <= '0;
      seen_q        <= 1'b0;
      hs_prev_q     <= 1'b1;
      vs_prev_q     <= 1'b1;
      locked_q      <= 1'b0;
      pix_valid_q   <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      pix_rgb_q     <= '0;
      frame_start_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      h_q           <= h_d;
      v_q           <= v_d;
      good_q        <= good_d;
      to_q          <= to_d;
      seen_q        <= seen_d;
      hs_prev_q     <= hs_prev_d;
      vs_prev_q     <= vs_prev_d;
      locked_q      <= locked_d;
      pix_valid_q   <= pix_valid_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      pix_rgb_q     <= pix_rgb_d;
      frame_start_q <= frame_start_d;
      sync_err_q    <= sync_err_d;
    end
  end

  assign vif.locked      = locked_q;
  assign vif.pix_valid   = pix_valid_q;
  assign vif.pix_x       = pix_x_q;
  assign vif.pix_y       = pix_y_q;
  assign vif.pix_rgb     = pix_rgb_q;
  assign vif.frame_start = frame_start_q;
  assign vif.sync_err    = sync_err_q;

`ifdef VGA_DEC_STATS_EN
  // Error count holds at full scale instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] val);
    return (val == 8'hff) ? val : val + 8'd1;
  endfunction

  logic [15:0] frame_cnt_q;
  logic [7:0]  err_cnt_q;

  // Statistics advance together with the strobes they count.
  always_ff @(posedge clk) begin
    if (clr) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (frame_start_d) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (sync_err_d)    err_cnt_q   <= sat_inc8(err_cnt_q);
    end
  end

  assign vif.frame_cnt = frame_cnt_q;
  assign vif.err_cnt   = err_cnt_q;
`endif

endmodule
